// File: rtl/c15xx_head_ctrl_if.sv
// c15xx_head_ctrl_if
// Save-request handshake between the head controller and the SD track loader.
// The head controller presents the oldest pending save on save_req/save_track/
// save_side. The loader answers with a one-ce save_ack pulse, which removes
// that entry from the queue.
//   save_req    controller -> loader  level, a save is pending
//   save_track  controller -> loader  track to write back
//   save_side   controller -> loader  head side to write back
//   save_ovf    controller -> loader  sticky, the queue overflowed
//   save_ack    loader -> controller  one-ce pulse, head entry consumed
interface c15xx_head_ctrl_if;
  logic       save_req;
  logic [5:0] save_track;
  logic       save_side;
  logic       save_ovf;
  logic       save_ack;

  modport master (
    output save_req,
    output save_track,
    output save_side,
    output save_ovf,
    input  save_ack
  );

  modport slave (
    input  save_req,
    input  save_track,
    input  save_side,
    input  save_ovf,
    output save_ack
  );
endinterface

// File: rtl/c15xx_head_ctrl.sv
// c15xx_head_ctrl
// Head positioner and track-dirty manager for the c15xx drive cores.
// It decodes the stepper phases into a clamped half-track position and
// selects the head side. It generates write-protect/disk-change sense and
// track-00 sense. It also records buffer writes and queues save requests
// (two entries deep) for the SD track loader.
// Optional feature macro: HEAD_SETTLE_EN. When it is defined, each step
// starts a SETTLE_CYC head-settle window. During that window, buffer writes
// do not mark the track dirty.
// Ports:
//   clk, reset_n       core clock, synchronous active-low reset
//   ce                 clock enable for all non-reset state
//   disk_change        image-change level (rising edge is the event)
//   disk_readonly      readonly flag, latched on disk_change rise
//   mtr, stp           spindle motor and stepper phases
//   act                activity LED, falling edge triggers a save
//   side               requested head side (used when SIDES=2)
//   buff_we            track buffer write strobe
//   wps_n, tr00_sense_n write-protect and track-00 sense
//   half_track, track  current head position
//   head_side          active head side
//   settling           head settle in progress
//   save_bus           save handshake (master side)
module c15xx_head_ctrl #(
  parameter int MIN_HT    = 1,
  parameter int MAX_HT    = 80,
  parameter int RESET_HT  = 36,
  parameter int SIDES     = 1,
  parameter int WP_CYCLES = 7500000
`ifdef HEAD_SETTLE_EN
  ,
  parameter int SETTLE_CYC = 4800
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       disk_change,
  input  logic       disk_readonly,
  input  logic       mtr,
  input  logic       act,
  input  logic [1:0] stp,
  input  logic       side,
  input  logic       buff_we,
  output logic       wps_n,
  output logic       tr00_sense_n,
  output logic [6:0] half_track,
  output logic [5:0] track,
  output logic       head_side,
  output logic       settling,
  c15xx_head_ctrl_if.master save_bus
);

  localparam int CH_W = (WP_CYCLES > 1) ? $clog2(WP_CYCLES + 1) : 1;

  typedef struct packed {
    logic [5:0] trk;
    logic       sd;
  } entry_t;

  logic [1:0]      stp_r;
  logic            act_r;
  logic            dc_r;
  logic            readonly;
  logic [CH_W-1:0] ch_cnt;
  logic            dirty;
  entry_t          q0;
  entry_t          q1;
  logic [1:0]      q_cnt;
  logic            ovf;

  logic   fwd;
  logic   rev;
  logic   step;
  logic   side_next;
  logic   side_chg;
  logic   act_fall;
  logic   dc_rise;
  logic   leave;
  logic   enq;
  logic   pop;
  logic   we_eff;
  entry_t new_entry;

  // The phase sequence 0,2,1,3 moves the head inward. Walking it backwards
  // moves the head outward. A jump of two phases cannot be resolved, so it
  // is ignored.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({stp_r, stp})
      4'b00_10, 4'b10_01, 4'b01_11, 4'b11_00: fwd = 1'b1;
      4'b00_11, 4'b10_00, 4'b01_10, 4'b11_01: rev = 1'b1;
      default: ;
    endcase
  end

  // A step counts as a track leave even when the head is clamped at the end
  // stop. The image logic cannot tell the difference.
  assign step      = ce & mtr & (fwd | rev);
  assign side_next = (SIDES > 1) ? side : 1'b0;
  assign side_chg  = ce & (side_next != head_side);
  assign act_fall  = ce & act_r & ~act;
  assign dc_rise   = ce & disk_change & ~dc_r;
  assign leave     = step | side_chg | act_fall;
  assign enq       = leave & dirty;
  assign pop       = ce & save_bus.save_ack & (q_cnt != 2'd0);
  assign we_eff    = buff_we & ~settling;
  assign new_entry = '{trk: half_track[6:1], sd: head_side};

  // Head position, side selection and edge-detect history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_track <= 7'(RESET_HT);
      head_side  <= 1'b0;
      stp_r      <= 2'd0;
      act_r      <= 1'b0;
      dc_r       <= 1'b0;
    end else if (ce) begin
      stp_r     <= stp;
      act_r     <= act;
      dc_r      <= disk_change;
      head_side <= side_next;
      if (step && fwd && half_track < 7'(MAX_HT))
        half_track <= half_track + 7'd1;
      else if (step && rev && half_track > 7'(MIN_HT))
        half_track <= half_track - 7'd1;
    end
  end

  // Disk change: latch the readonly flag and start the window in which the
  // write-protect sense is inverted. The DOS watches for this toggle to
  // detect a disk swap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readonly <= 1'b0;
      ch_cnt   <= '0;
    end else if (ce) begin
      if (dc_rise) begin
        readonly <= disk_readonly;
        ch_cnt   <= CH_W'(WP_CYCLES);
      end else if (ch_cnt != '0) begin
        ch_cnt <= ch_cnt - 1'b1;
      end
    end
  end

  // Dirty flag. A disk change discards pending modifications, and that clear
  // wins over a write in the same ce. On a track leave, the flag moves into
  // the queue. A write in that same ce then belongs to the new track.
  always_ff @(posedge clk) begin
    if (!reset_n)
      dirty <= 1'b0;
    else if (ce) begin
      if (dc_rise)
        dirty <= 1'b0;
      else if (leave)
        dirty <= we_eff;
      else if (we_eff)
        dirty <= 1'b1;
    end
  end

  // Two-entry save queue, with q0 as the head. When the queue is full, a new
  // entry replaces the newest one. The head entry is kept because the loader
  // may already be working on it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q0    <= '0;
      q1    <= '0;
      q_cnt <= 2'd0;
      ovf   <= 1'b0;
    end else if (ce) begin
      if (enq && pop) begin
        if (q_cnt == 2'd1) begin
          q0 <= new_entry;
        end else begin
          q0 <= q1;
          q1 <= new_entry;
        end
      end else if (enq) begin
        case (q_cnt)
          2'd0: begin
            q0    <= new_entry;
            q_cnt <= 2'd1;
          end
          2'd1: begin
            q1    <= new_entry;
            q_cnt <= 2'd2;
          end
          default: begin
            q1  <= new_entry;
            ovf <= 1'b1;
          end
        endcase
      end else if (pop) begin
        q0    <= q1;
        q_cnt <= q_cnt - 2'd1;
      end
    end
  end

`ifdef HEAD_SETTLE_EN
  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  logic [ST_W-1:0] st_cnt;

  // Settle window after each step. Writes made while the head is still
  // moving would land on the wrong track, so they are not counted as dirty.
  always_ff @(posedge clk) begin
    if (!reset_n)
      st_cnt <= '0;
    else if (ce) begin
      if (step)
        st_cnt <= ST_W'(SETTLE_CYC);
      else if (st_cnt != '0)
        st_cnt <= st_cnt - 1'b1;
    end
  end

  assign settling = (st_cnt != '0);
`else
  assign settling = 1'b0;
`endif

  assign track                = half_track[6:1];
  assign tr00_sense_n         = (track != 6'd0);
  assign wps_n                = ~readonly ^ (ch_cnt != '0);
  assign save_bus.save_req    = (q_cnt != 2'd0);
  assign save_bus.save_track  = q0.trk;
  assign save_bus.save_side   = q0.sd;
  assign save_bus.save_ovf    = ovf;

endmodule
